// File: rtl/xmit.sv
// Serial frame transmitter: each byte from a one-entry holding buffer goes out
// as a MATCH header byte followed by the data byte, both MSB first.
module xmit #(
  parameter logic [7:0] MATCH = 8'hA5,
  parameter logic       IDLE  = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       writing,
  output logic       serial_out,
  output logic       empty,
  output logic       busy,
  output logic       overrun
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HEAD = 2'd1,
    ST_BODY = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic [7:0]  frame_q, frame_d;
  logic [2:0]  count_q, count_d;
  logic        ser_q, ser_d;
  logic        empty_q, empty_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;
  logic        take;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hold_q    <= 8'h00;
      frame_q   <= 8'h00;
      count_q   <= 3'd0;
      ser_q     <= IDLE;
      empty_q   <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      frame_q   <= frame_d;
      count_q   <= count_d;
      ser_q     <= ser_d;
      empty_q   <= empty_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    frame_d   = frame_q;
    count_d   = count_q;
    ser_d     = ser_q;
    empty_d   = empty_q;
    busy_d    = busy_q;
    overrun_d = overrun_q;
    take      = 1'b0;

    // Write port and take never both touch empty: one needs empty_q=1, the other 0.
    if (writing) begin
      if (empty_q) begin
        hold_d    = data_in;
        empty_d   = 1'b0;
        overrun_d = 1'b0;
      end else begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (!empty_q) begin
          take = 1'b1;
        end else begin
          ser_d  = IDLE;
          busy_d = 1'b0;
        end
      end
      ST_HEAD: begin
        if (count_q != 3'd7) begin
          ser_d   = MATCH[3'd6 - count_q];
          count_d = count_q + 3'd1;
        end else begin
          ser_d   = frame_q[7];
          count_d = 3'd0;
          state_d = ST_BODY;
        end
      end
      ST_BODY: begin
        if (count_q != 3'd7) begin
          ser_d   = frame_q[3'd6 - count_q];
          count_d = count_q + 3'd1;
        end else if (!empty_q) begin
          take = 1'b1;
        end else begin
          ser_d   = IDLE;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        ser_d   = IDLE;
        busy_d  = 1'b0;
        count_d = 3'd0;
        state_d = ST_IDLE;
      end
    endcase

    // Taking a byte starts a frame identically from IDLE or back-to-back from BODY.
    if (take) begin
      frame_d = hold_q;
      empty_d = 1'b1;
      count_d = 3'd0;
      busy_d  = 1'b1;
      ser_d   = MATCH[7];
      state_d = ST_HEAD;
    end
  end

  assign serial_out = ser_q;
  assign empty      = empty_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_xmit.sv
// Directed bench for xmit: default instance plus one with MATCH=8'h96, IDLE=1.
module tb_xmit;

  logic       clock;
  logic       reset;
  logic [7:0] data_in, data_in2;
  logic       writing, writing2;
  logic       serial_out, empty, busy, overrun;
  logic       serial_out2, empty2, busy2, overrun2;

  int checks = 0;
  int errors = 0;

  xmit u_dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .writing    (writing),
    .serial_out (serial_out),
    .empty      (empty),
    .busy       (busy),
    .overrun    (overrun)
  );

  xmit #(.MATCH(8'h96), .IDLE(1'b1)) u_dut2 (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in2),
    .writing    (writing2),
    .serial_out (serial_out2),
    .empty      (empty2),
    .busy       (busy2),
    .overrun    (overrun2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks the last n bits of bits, MSB first, one per cycle, with busy high.
  task automatic check_stream(input bit sel, input logic [31:0] bits, input int n,
                              input string tag);
    for (int k = 0; k < n; k++) begin
      tick();
      chk($sformatf("%s bit%0d", tag, k), {7'd0, sel ? serial_out2 : serial_out},
          {7'd0, bits[n-1-k]});
      chk($sformatf("%s busy%0d", tag, k), {7'd0, sel ? busy2 : busy}, 8'd1);
    end
    $display("stream %s: %0d bits checked", tag, n);
  endtask

  task automatic write_byte(input logic [7:0] b);
    data_in = b;
    writing = 1'b1;
    tick();
    writing = 1'b0;
    $display("write %h", b);
  endtask

  initial begin
    reset = 1'b1; writing = 1'b0; writing2 = 1'b0;
    data_in = 8'h00; data_in2 = 8'h00;
    #12;
    chk("rst serial", {7'd0, serial_out}, 8'd0);
    chk("rst empty", {7'd0, empty}, 8'd1);
    chk("rst busy", {7'd0, busy}, 8'd0);
    chk("rst overrun", {7'd0, overrun}, 8'd0);
    chk("rst serial2", {7'd0, serial_out2}, 8'd1);
    #1 reset = 1'b0;
    tick();
    chk("post-rst serial", {7'd0, serial_out}, 8'd0);
    chk("post-rst serial2", {7'd0, serial_out2}, 8'd1);

    // Single byte 3C
    write_byte(8'h3C);
    chk("accept empty", {7'd0, empty}, 8'd0);
    check_stream(1'b0, 32'h0000_A53C, 16, "single3C");
    tick();
    chk("single end serial", {7'd0, serial_out}, 8'd0);
    chk("single end busy", {7'd0, busy}, 8'd0);
    chk("single end empty", {7'd0, empty}, 8'd1);

    // Back-to-back 00 then FF, second written at E2
    write_byte(8'h00);
    tick();
    chk("b2b bit0", {7'd0, serial_out}, 8'd1);
    chk("b2b empty after take", {7'd0, empty}, 8'd1);
    data_in = 8'hFF; writing = 1'b1;
    tick();
    writing = 1'b0;
    chk("b2b bit1", {7'd0, serial_out}, 8'd0);
    chk("b2b empty after write", {7'd0, empty}, 8'd0);
    check_stream(1'b0, 32'hA500_A5FF, 30, "b2b");
    tick();
    chk("b2b end serial", {7'd0, serial_out}, 8'd0);
    chk("b2b end busy", {7'd0, busy}, 8'd0);

    // Overrun: 22 collides with the take at E1, 33 accepted at E2
    write_byte(8'h11);
    data_in = 8'h22; writing = 1'b1;
    tick();
    chk("ovr set", {7'd0, overrun}, 8'd1);
    chk("ovr bit0", {7'd0, serial_out}, 8'd1);
    data_in = 8'h33;
    tick();
    writing = 1'b0;
    chk("ovr clear", {7'd0, overrun}, 8'd0);
    chk("ovr bit1", {7'd0, serial_out}, 8'd0);
    check_stream(1'b0, 32'hA511_A533, 30, "ovr");
    tick();
    chk("ovr end serial", {7'd0, serial_out}, 8'd0);
    chk("ovr end busy", {7'd0, busy}, 8'd0);

    // Body equal to header
    write_byte(8'hA5);
    check_stream(1'b0, 32'h0000_A5A5, 16, "bodyA5");
    tick();
    chk("A5 end serial", {7'd0, serial_out}, 8'd0);

    // Reset mid-frame with hold full and overrun set
    write_byte(8'h55);
    tick();
    data_in = 8'h66; writing = 1'b1;
    tick();
    data_in = 8'h77;
    tick();
    writing = 1'b0;
    chk("pre-rst overrun", {7'd0, overrun}, 8'd1);
    chk("pre-rst empty", {7'd0, empty}, 8'd0);
    repeat (8) tick();
    chk("pre-rst busy", {7'd0, busy}, 8'd1);
    #2 reset = 1'b1;
    #1;
    chk("midrst serial", {7'd0, serial_out}, 8'd0);
    chk("midrst busy", {7'd0, busy}, 8'd0);
    chk("midrst empty", {7'd0, empty}, 8'd1);
    chk("midrst overrun", {7'd0, overrun}, 8'd0);
    #2 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("after-rst serial%0d", i), {7'd0, serial_out}, 8'd0);
      chk($sformatf("after-rst busy%0d", i), {7'd0, busy}, 8'd0);
    end
    $display("reset mid-frame done");

    // Alternate parameters: MATCH=96, idle level 1
    chk("p2 idle", {7'd0, serial_out2}, 8'd1);
    data_in2 = 8'h0F; writing2 = 1'b1;
    tick();
    writing2 = 1'b0;
    $display("write2 0F");
    check_stream(1'b1, 32'h0000_960F, 16, "p2");
    tick();
    chk("p2 end serial", {7'd0, serial_out2}, 8'd1);
    chk("p2 end busy", {7'd0, busy2}, 8'd0);
    tick();
    chk("p2 idle again", {7'd0, serial_out2}, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/xmit.md
# xmit

Serial frame transmitter, the sending end of the header-match serial link. Accepts bytes from a parallel writer through a one-entry holding buffer. Sends each byte as a 16-bit frame on a single serial line: the 8-bit `MATCH` header, then the 8 data bits, both MSB first. Frames are contiguous when bytes are supplied fast enough, so the downstream `rcvr` with the same `MATCH` recovers every byte.

## Interface
- `MATCH`, 8'hA5, header character sent before every data byte, MSB first.
- `IDLE`, 1'b0, level driven on `serial_out` while no frame is in progress.

- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `data_in`  in  8  byte to transmit; sampled only on an accepted write.
- `writing`  in  1  write strobe, one byte per sampled cycle.
- `serial_out`  out  1  registered serial line.
- `empty`  out  1  holding buffer free; a write is accepted only when `empty`=1 at the sampling edge.
- `busy`  out  1  a frame is on the line.
- `overrun`  out  1  sticky flag: a write was rejected because the buffer was full.

## Operation
- Storage: 8-bit holding register `hold`, 8-bit frame register, 3-bit bit counter, FSM with states IDLE, HEAD, BODY.
- Write port, evaluated every edge:
  - `writing`=1 and `empty`=1: `hold`<=`data_in`, `empty`<=0, `overrun`<=0.
  - `writing`=1 and `empty`=0: write discarded, `hold` unchanged, `overrun`<=1.
  - `writing`=0: no change.
- FSM:
  - **IDLE** with `empty`=0: the FSM takes the byte.
    - Frame register <= `hold`, `empty`<=1, count<=0, `busy`<=1.
    - `serial_out`<=`MATCH[7]`, state -> HEAD.
  - **IDLE** with `empty`=1: `serial_out`<=`IDLE`, `busy`=0.
  - **HEAD**, count c<7: `serial_out`<=`MATCH[6-c]`, count<=c+1.
  - **HEAD**, count 7: `serial_out`<=frame[7], count<=0, state -> BODY.
  - **BODY**, count c<7: `serial_out`<=frame[6-c], count<=c+1.
  - **BODY**, count 7, `empty`=0 (back-to-back): take the next byte exactly as from IDLE. `serial_out`<=`MATCH[7]`, state -> HEAD, `busy` stays 1.
  - **BODY**, count 7, `empty`=1: `serial_out`<=`IDLE`, `busy`<=0, state -> IDLE.
- Simultaneous write and take on the same edge: the write sees `empty`=0 and is rejected with `overrun`<=1. The take proceeds with the old `hold`.
- A write accepted in the same edge that `empty` is set by a take cannot happen, because the write port samples the pre-edge `empty`.
- Counter wrap 7 -> 0 is the only counter arithmetic.
- Data bits are sent unmodified. No escaping is done when a body byte equals `MATCH`.

## Timing
- Reset (asynchronous, any time, including mid-frame):
  - State IDLE, count 0.
  - `serial_out`=`IDLE`, `empty`=1, `busy`=0, `overrun`=0.
  - The frame in progress and `hold` are discarded.
- First release edge after reset: normal operation.
- Latency, write accepted at edge E0 while IDLE:
  - E1: the FSM takes the byte; `empty` returns to 1 after E1.
  - `serial_out` = `MATCH[7]` from E1 to E2.
  - Header bit k is on the line from edge E1+k.
  - Data bit d[7-k] is on the line from edge E9+k.
  - `busy`=1 from E1 through E17 (cycles E1..E16 carry the frame).
- Frame length: 16 cycles. Back-to-back frames have zero gap cycles.
- Buffer turnaround: after a take, the next write can be accepted at the following edge. The writer then has 15 cycles to supply it for a gapless stream.
- `overrun` changes only on write attempts and reset.

## Test plan
- Reset mid-frame: assert `reset` between clock edges during BODY -> immediately `serial_out`=0, `busy`=0, `empty`=1, `overrun`=0. After release, the line stays 0 until a write.
- Single byte 8'h3C, written while idle -> starting one edge after the write, 16 cycles on `serial_out` read 1010_0101_0011_1100. `busy` is high for exactly those 16 cycles, and the line returns to 0. A `rcvr` with `MATCH`=8'hA5 reports `data_out`=8'h3C with `ready`.
- Back-to-back: write 8'h00, then 8'hFF one cycle after `empty` rises -> 32 contiguous bits 1010_0101_0000_0000_1010_0101_1111_1111, with no idle gap and `busy` held high throughout.
- Overrun:
  - Write 8'h11 while idle, then write 8'h22 on the same edge as the take (`empty`=0) -> 8'h22 is dropped and `overrun`=1.
  - Next write 8'h33 with `empty`=1 -> `overrun`=0. Frames carry 8'h11 then 8'h33.
- Body equal to header: write 8'hA5 -> 16 bits 1010_0101_1010_0101. The receiver still outputs 8'hA5.
- Parameters `MATCH`=8'h96, `IDLE`=1 -> the idle line is held at 1. Write 8'h0F -> 1001_0110_0000_1111, then the line returns to 1.
